pwm_deadtime_modulator: RTL and testbench

//  Multi-channel carrier-compare PWM stage that replaces the single-channel comparator behind the DDS

---
 rtl/pwm_deadtime_modulator.sv | 137 +++++++++++++
 tb/tb_pwm_deadtime_modulator.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime_modulator.sv
// Multi-channel carrier-compare PWM with double-buffered references
// and complementary gate outputs separated by a programmable dead-band.
module pwm_deadtime_modulator #(
   parameter int CH   = 3,
   parameter int DW   = 16,
   parameter int DT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [CH*DW-1:0] ref_in,
   input  logic             ref_valid,
   input  logic [DW-1:0]    carrier,
   input  logic             carrier_sync,
   input  logic [DT_W-1:0]  dead_time,
   output logic [CH-1:0]    pwm_raw,
   output logic [CH-1:0]    gate_hi,
   output logic [CH-1:0]    gate_lo
);

   typedef enum logic [2:0] {
      S_OFF,
      S_LO,
      S_DT_R,
      S_HI,
      S_DT_F
   } state_t;

   logic [DW-1:0]   stg_q [CH];
   logic [DW-1:0]   stg_d [CH];
   logic [DW-1:0]   act_q [CH];
   logic [DW-1:0]   act_d [CH];
   logic [CH-1:0]   raw_q, raw_d;
   logic [CH-1:0]   hi_q, hi_d;
   logic [CH-1:0]   lo_q, lo_d;
   state_t          st_q [CH];
   state_t          st_d [CH];
   logic [DT_W-1:0] cnt_q [CH];
   logic [DT_W-1:0] cnt_d [CH];

   // A simultaneous strobe and sync bypasses staging so the new
   // reference takes effect at this extremum rather than the next.
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         stg_d[i] = stg_q[i];
         act_d[i] = act_q[i];
         if (ref_valid)
            stg_d[i] = ref_in[i*DW +: DW];
         if (carrier_sync)
            act_d[i] = ref_valid ? ref_in[i*DW +: DW] : stg_q[i];
         raw_d[i] = $signed(act_q[i]) >= $signed(carrier);
      end
   end

   always_comb begin
      for (int i = 0; i < CH; i++) begin
         st_d[i]  = st_q[i];
         cnt_d[i] = cnt_q[i];
         if (!enable) begin
            st_d[i] = S_OFF;
         end else begin
            unique case (st_q[i])
               S_OFF: st_d[i] = S_LO;
               S_LO: begin
                  if (raw_q[i]) begin
                     if (dead_time != '0) begin
                        st_d[i]  = S_DT_R;
                        cnt_d[i] = dead_time - DT_W'(1);
                     end else begin
                        st_d[i] = S_HI;
                     end
                  end
               end
               S_DT_R: begin
                  if (!raw_q[i])
                     st_d[i] = S_LO;
                  else if (cnt_q[i] == '0)
                     st_d[i] = S_HI;
                  else
                     cnt_d[i] = cnt_q[i] - DT_W'(1);
               end
               S_HI: begin
                  if (!raw_q[i]) begin
                     if (dead_time != '0) begin
                        st_d[i]  = S_DT_F;
                        cnt_d[i] = dead_time - DT_W'(1);
                     end else begin
                        st_d[i] = S_LO;
                     end
                  end
               end
               S_DT_F: begin
                  if (raw_q[i])
                     st_d[i] = S_HI;
                  else if (cnt_q[i] == '0)
                     st_d[i] = S_LO;
                  else
                     cnt_d[i] = cnt_q[i] - DT_W'(1);
               end
               default: st_d[i] = S_OFF;
            endcase
         end
         // Gates are registered from the next state to stay glitch-free.
         hi_d[i] = (st_d[i] == S_HI);
         lo_d[i] = (st_d[i] == S_LO);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < CH; i++) begin
            stg_q[i] <= '0;
            act_q[i] <= '0;
            st_q[i]  <= S_OFF;
            cnt_q[i] <= '0;
         end
         raw_q <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            stg_q[i] <= stg_d[i];
            act_q[i] <= act_d[i];
            st_q[i]  <= st_d[i];
            cnt_q[i] <= cnt_d[i];
         end
         raw_q <= raw_d;
         hi_q  <= hi_d;
         lo_q  <= lo_d;
      end
   end

   assign pwm_raw = raw_q;
   assign gate_hi = hi_q;
   assign gate_lo = lo_q;

endmodule

// File: tb/tb_pwm_deadtime_modulator.sv
// Scoreboard bench for pwm_deadtime_modulator: a per-cycle reference model
// pushes expected outputs; a monitor pops and compares after each edge.
module tb_pwm_deadtime_modulator;
   localparam int CH   = 3;
   localparam int DW   = 16;
   localparam int DT_W = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             enable;
   logic [CH*DW-1:0] ref_in;
   logic             ref_valid;
   logic [DW-1:0]    carrier;
   logic             carrier_sync;
   logic [DT_W-1:0]  dead_time;
   logic [CH-1:0]    pwm_raw;
   logic [CH-1:0]    gate_hi;
   logic [CH-1:0]    gate_lo;

   pwm_deadtime_modulator #(.CH(CH), .DW(DW), .DT_W(DT_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .ref_in       (ref_in),
      .ref_valid    (ref_valid),
      .carrier      (carrier),
      .carrier_sync (carrier_sync),
      .dead_time    (dead_time),
      .pwm_raw      (pwm_raw),
      .gate_hi      (gate_hi),
      .gate_lo      (gate_lo)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [CH-1:0] raw;
      logic [CH-1:0] hi;
      logic [CH-1:0] lo;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   // stimulus for the next edge
   bit               s_rst, s_en, s_rv, s_sy;
   logic [CH*DW-1:0] s_ref;
   logic [DW-1:0]    s_car;
   logic [DT_W-1:0]  s_dt;

   // model: references, compare result, and per-channel gate side with
   // a run-length count of compare samples disagreeing with that side
   logic [DW-1:0] m_act [CH];
   logic [DW-1:0] m_stg [CH];
   bit            m_raw [CH];
   bit            m_on  [CH];
   bit            m_side[CH];
   int            m_run [CH];
   int            m_dcap[CH];

   task automatic check(input string name, input logic [CH-1:0] got,
                        input logic [CH-1:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, got, want);
      end
   endtask

   function automatic logic [CH*DW-1:0] refs(input logic [DW-1:0] a,
                                             input logic [DW-1:0] b,
                                             input logic [DW-1:0] c);
      return {c, b, a};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < CH; i++) begin
         m_act[i]  = '0;
         m_stg[i]  = '0;
         m_raw[i]  = 1'b0;
         m_on[i]   = 1'b0;
         m_side[i] = 1'b0;
         m_run[i]  = 0;
         m_dcap[i] = 0;
      end
   endtask

   task automatic step();
      exp_t e;
      @(negedge clk);
      reset        = s_rst;
      enable       = s_en;
      ref_valid    = s_rv;
      carrier_sync = s_sy;
      ref_in       = s_ref;
      carrier      = s_car;
      dead_time    = s_dt;
      e = '0;
      if (s_rst) begin
         #1;
         check("async_reset_raw", pwm_raw, '0);
         check("async_reset_hi", gate_hi, '0);
         check("async_reset_lo", gate_lo, '0);
         model_reset();
      end else begin
         for (int i = 0; i < CH; i++) begin
            bit r_old;
            r_old = m_raw[i];
            if (!s_en) begin
               m_on[i] = 1'b0;
            end else if (!m_on[i]) begin
               m_on[i]   = 1'b1;
               m_side[i] = 1'b0;
               m_run[i]  = 0;
            end else if (r_old == m_side[i]) begin
               m_run[i] = 0;
            end else begin
               if (m_run[i] == 0)
                  m_dcap[i] = int'(s_dt);
               m_run[i]++;
               if (m_run[i] > m_dcap[i]) begin
                  m_side[i] = r_old;
                  m_run[i]  = 0;
               end
            end
            e.hi[i]  = m_on[i] && m_run[i] == 0 && m_side[i];
            e.lo[i]  = m_on[i] && m_run[i] == 0 && !m_side[i];
            m_raw[i] = $signed(m_act[i]) >= $signed(s_car);
            e.raw[i] = m_raw[i];
            if (s_sy)
               m_act[i] = s_rv ? s_ref[i*DW +: DW] : m_stg[i];
            if (s_rv)
               m_stg[i] = s_ref[i*DW +: DW];
         end
      end
      exp_q.push_back(e);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pwm_raw", pwm_raw, e.raw);
            check("gate_hi", gate_hi, e.hi);
            check("gate_lo", gate_lo, e.lo);
            check("overlap", gate_hi & gate_lo, '0);
         end
      end
   end

   function automatic logic [DW-1:0] tri_car(input int k);
      int p;
      p = k % 64;
      if (p < 32)
         return DW'(-16384 + p * 1024);
      return DW'(16384 - (p - 32) * 1024);
   endfunction

   initial begin
      s_rst = 1; s_en = 0; s_rv = 0; s_sy = 0;
      s_ref = '0; s_car = '0; s_dt = '0;
      model_reset();
      repeat (3) step();

      // reset state: active refs are 0, so carrier -1 / +1 decide pwm_raw
      s_rst = 0; s_en = 0;
      s_car = 16'hFFFF; step();
      s_car = 16'h0001; step();

      // sawtooth, zero dead-time
      s_en = 1; s_dt = 0;
      s_ref = refs(16'h1000, 16'hC000, 16'h0000);
      s_rv = 1; s_sy = 1; step();
      s_rv = 0; s_sy = 0;
      for (int k = 0; k < 200; k++) begin
         s_car = DW'(-32768 + (k % 64) * 1024);
         s_sy  = (k % 64 == 0);
         step();
      end

      // triangle, dead-time 5, mid-period staging then same-cycle load
      s_dt  = 5;
      s_ref = refs(16'h0800, 16'hF000, 16'h3000);
      s_rv = 1; s_sy = 1; step();
      s_rv = 0; s_sy = 0;
      for (int k = 0; k < 320; k++) begin
         s_car = tri_car(k);
         s_sy  = (k % 32 == 0);
         s_rv  = (k == 80 || k == 200 || k == 230);
         if (k == 80)  s_ref = refs(16'h2000, 16'h2000, 16'h2000);
         if (k == 200) s_ref = refs(16'hE000, 16'h1000, 16'h0000);
         if (k == 230) s_ref = refs(16'h0400, 16'hC400, 16'h3C00);
         if (k == 300) begin s_rv = 1; s_sy = 1; s_ref = refs(16'h2000, 16'h0000, 16'hE000); end
         step();
      end
      s_rv = 0; s_sy = 0;

      // short compare pulses around the dead-band length
      s_ref = refs(16'h0000, 16'h0000, 16'h0000);
      s_rv = 1; s_sy = 1; s_car = 16'h0100; step();
      s_rv = 0; s_sy = 0;
      for (int n = 0; n < 30; n++) begin
         int len;
         len = $urandom_range(1, 9);
         s_car = 16'hFF00;
         repeat (len) step();
         s_car = 16'h0100;
         repeat ($urandom_range(1, 10)) step();
      end

      // enable drop while high, reset in the middle of a dead-band
      s_car = 16'hFF00;
      repeat (10) step();
      s_en = 0; step(); step();
      s_en = 1;
      repeat (12) step();
      s_dt = 20; s_car = 16'h0100;
      repeat (30) step();
      s_car = 16'hFF00;
      repeat (4) step();
      s_rst = 1; step();
      s_rst = 0;
      repeat (4) step();

      // signed compare extremes
      s_dt = 0;
      s_ref = refs(16'h7FFF, 16'h8000, 16'h8000);
      s_rv = 1; s_sy = 1; step();
      s_rv = 0; s_sy = 0;
      s_car = 16'h7FFF; repeat (3) step();
      s_car = 16'h8000; repeat (3) step();
      s_car = 16'h8001; repeat (3) step();
      s_ref = refs(16'h8000, 16'h7FFF, 16'h8001);
      s_rv = 1; s_sy = 1; step();
      s_rv = 0; s_sy = 0;
      s_car = 16'h8000; repeat (3) step();
      s_car = 16'h8001; repeat (3) step();

      // randomized mix
      for (int k = 0; k < 1500; k++) begin
         s_rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 49) == 0)
            s_en = ~s_en;
         if ($urandom_range(0, 99) == 0)
            s_dt = DT_W'($urandom_range(0, 8));
         s_rv  = ($urandom_range(0, 9) == 0);
         s_sy  = ($urandom_range(0, 15) == 0);
         s_ref = {CH*DW{1'b0}} | {DW'($urandom), DW'($urandom), DW'($urandom)};
         if ($urandom_range(0, 3) == 0)
            s_car = DW'($urandom);
         else
            s_car = tri_car(k);
         step();
      end
      s_rst = 0; s_en = 1; s_rv = 0; s_sy = 0;
      repeat (3) step();

      @(posedge clk);
      #3;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
